motor_ramp: RTL and testbench
=============================

// Module: motor_ramp
// PURPOSE
// Slew-rate limiter between the SPI motor-command latch/watchdog and each Motor_Wrapper (one instance per motor).
// Takes the raw commanded direction, 9-bit speed and drive mode. Produces a ramped speed/direction that never steps
// by more than STEP per tick. Reverses direction only after decelerating to zero and dwelling there.
// An estop input (driven by watchdog timeout) forces an immediate stop.
// PARAMETERS
// STEP         4      speed change per tick, 1..511
// TICK_DIV     2304   sysclk cycles per ramp tick (8 kHz at 18.432 MHz), >=2
// DWELL_TICKS  8      ticks held at speed 0 before a direction flip, >=1
// PORTS
// sysclk          in   1  system clock, all logic on rising edge
// rst             in   1  synchronous, active-high reset
// cmd_valid       in   1  one-cycle strobe: latch cmd_dir/cmd_speed/cmd_mode as new target
// cmd_dir         in   1  commanded direction
// cmd_speed       in   9  commanded speed magnitude, 0..511
// cmd_mode        in   2  commanded drive mode
// estop           in   1  level; while high, force stop and clear target
// out_dir         out  1  ramped direction to Motor_Wrapper
// out_speed       out  9  ramped speed to Motor_Wrapper
// out_mode        out  2  drive mode to Motor_Wrapper
// ramping         out  1  high while outputs differ from target or in DWELL
// reversal_count  out  8  saturating count of out_dir flips
// BEHAVIOUR
// - All outputs registered. Reset: target={0,0,0}, out_dir=0, out_speed=0, out_mode=0, ramping=0,
//   reversal_count=0, state=TRACK, prescaler=0, dwell_cnt=0. Reset mid-operation (incl. DWELL) gives the same values.
// - Prescaler: free-running 0..TICK_DIV-1. tick=1 in the cycle prescaler==TICK_DIV-1; first tick TICK_DIV-1 cycles after reset.
//   Not reset by estop or cmd_valid.
// - cmd_valid: target latched at that edge. A tick in the same cycle uses the OLD target.
//   out_mode <= cmd_mode in the same edge (1-cycle latency, no ramp).
// - Priority per cycle: rst > estop > tick/cmd.
// - estop=1: out_speed<=0, out_mode<=0, target<={dir 0, speed 0, mode 0}, state<=TRACK, dwell_cnt<=0.
//   out_dir is unchanged. Any cmd_valid in the same cycle is discarded. Ticks during estop have no effect.
// - State TRACK, on tick:
//   * out_dir==target_dir: out_speed moves toward target_speed by min(STEP, |diff|). Exact landing, never overshoots.
//     Math is 10-bit; result clamped to 0..511, never wraps.
//   * out_dir!=target_dir, out_speed>0: out_speed <= max(out_speed-STEP, 0).
//   * out_dir!=target_dir, out_speed==0: state<=DWELL, dwell_cnt<=0.
// - State DWELL: out_speed held 0.
//   * Cycle target_dir==out_dir (cmd changed back): state<=TRACK next edge, no flip, dwell_cnt cleared.
//   * Else on tick: if dwell_cnt==DWELL_TICKS-1, then out_dir<=target_dir, state<=TRACK,
//     reversal_count<=sat(reversal_count+1); else dwell_cnt++.
//   * The speed ramp in the new direction starts on the next tick after the flip.
// - ramping <= (state_next==DWELL) | (out_speed_next!=target_speed_next) | (out_dir_next!=target_dir_next).
//   Coherent with outputs in the same cycle.
// - reversal_count saturates at 255. It is cleared only by rst, not by estop.
// TESTING (STEP=4, TICK_DIV=16, DWELL_TICKS=3; "tick n" = nth tick after command)
// 1. Ramp up: cmd_valid dir0 spd10 mode1 -> out_mode=1 next cycle; out_speed 4,8,10 after ticks 1,2,3.
//    ramping falls with 10; stays 10 after.
// 2. Reversal: at dir0 spd8, cmd dir1 spd8 -> out_speed 4,0; 3 dwell ticks at 0 then out_dir=1;
//    then 4,8; reversal_count=1.
// 3. Dwell abort: during DWELL cmd dir0 spd8 -> TRACK next cycle, out_dir stays 0, speed 4,8,
//    reversal_count unchanged.
// 4. Estop: at dir1 spd200 mode2, estop=1 with cmd_valid spd300 -> next cycle out_speed=0, out_mode=0, target 0,
//    out_dir=1. estop released -> target is 0 so out_dir ramps back via DWELL to 0.
// 5. Boundaries: from 509 target 511 -> 511 (no wrap). From 3 target 2 -> 2.
//    From 511 reverse -> 507..3,0 (floor, no wrap). cmd_valid on tick cycle -> old target used that tick.
// 6. Saturation/reset: force 256 reversals -> count stays 255. rst mid-DWELL -> all outputs 0 next cycle.

Source files
------------

// File: rtl/motor_ramp.sv
// -----------------------------------------------------------------------------
// motor_ramp
//
// Slew-rate limiter that sits between the SPI motor-command latch/watchdog and
// one Motor_Wrapper. It takes a raw commanded direction/speed/mode and produces
// a ramped speed/direction that never changes by more than STEP per ramp tick.
//
// A direction reversal is never taken at speed. The output first decelerates
// to zero, then dwells at zero for DWELL_TICKS ticks, and only then flips
// out_dir. The ramp in the new direction begins on the following tick.
//
// estop (a level, driven by the watchdog) forces the outputs to a stop
// immediately and clears the stored target.
//
// Command handshake: cmd_valid is a one-cycle strobe with no ready/back-pressure.
// The command is accepted unconditionally at the rising edge where cmd_valid=1,
// except that estop=1 in the same cycle discards it.
//
// Ports
//   sysclk          in   1  system clock, rising edge
//   rst             in   1  synchronous, active-high reset
//   cmd_valid       in   1  strobe: latch cmd_dir/cmd_speed/cmd_mode as target
//   cmd_dir         in   1  commanded direction
//   cmd_speed       in   9  commanded speed magnitude
//   cmd_mode        in   2  commanded drive mode (passed through, not ramped)
//   estop           in   1  level; force stop and clear the target while high
//   out_dir         out  1  ramped direction
//   out_speed       out  9  ramped speed
//   out_mode        out  2  drive mode
//   ramping         out  1  outputs differ from the target, or dwelling
//   reversal_count  out  8  saturating count of out_dir flips
//   dbg_state       out  1  FSM state (0 = TRACK, 1 = DWELL)
// -----------------------------------------------------------------------------
module motor_ramp #(
  parameter int STEP        = 4,
  parameter int TICK_DIV    = 2304,
  parameter int DWELL_TICKS = 8
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic       cmd_dir,
  input  logic [8:0] cmd_speed,
  input  logic [1:0] cmd_mode,
  input  logic       estop,
  output logic       out_dir,
  output logic [8:0] out_speed,
  output logic [1:0] out_mode,
  output logic       ramping,
  output logic [7:0] reversal_count,
  output logic       dbg_state
);

  typedef enum logic {
    TRACK = 1'b0,
    DWELL = 1'b1
  } state_t;

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;

  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_ONE    = PW'(1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);
  localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
  localparam logic [9:0]    STEP10     = 10'(STEP);

  // Registered state
  state_t          state_q;
  logic [PW-1:0]   prescaler_q;
  logic [DW-1:0]   dwell_cnt_q;
  logic            tgt_dir_q;
  logic [8:0]      tgt_speed_q;

  // Next-state values
  state_t          state_n;
  logic [DW-1:0]   dwell_cnt_n;
  logic            tgt_dir_n;
  logic [8:0]      tgt_speed_n;
  logic            out_dir_n;
  logic [8:0]      out_speed_n;
  logic [1:0]      out_mode_n;
  logic            ramping_n;
  logic [7:0]      reversal_count_n;

  logic            tick;

  // Ramp arithmetic is done in 10 bits so neither direction can wrap.
  logic [9:0]      cur10;
  logic [9:0]      tgt10;
  logic [9:0]      gap10;
  logic [9:0]      toward10;
  logic [9:0]      decel10;

  function automatic logic [8:0] clamp9(input logic [9:0] v);
    return v[9] ? 9'h1FF : v[8:0];
  endfunction

  assign tick      = (prescaler_q == PRE_LAST);
  assign dbg_state = state_q;

  // Free-running prescaler; only rst restarts it.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      prescaler_q <= '0;
    end else if (tick) begin
      prescaler_q <= '0;
    end else begin
      prescaler_q <= prescaler_q + PRE_ONE;
    end
  end

  // Step toward the (current, pre-command) target by at most STEP, landing
  // exactly on it; and a floored decelerate-by-STEP for reversals.
  always_comb begin
    cur10    = {1'b0, out_speed};
    tgt10    = {1'b0, tgt_speed_q};
    gap10    = '0;
    toward10 = cur10;
    if (tgt10 > cur10) begin
      gap10    = tgt10 - cur10;
      toward10 = cur10 + ((gap10 < STEP10) ? gap10 : STEP10);
    end else begin
      gap10    = cur10 - tgt10;
      toward10 = cur10 - ((gap10 < STEP10) ? gap10 : STEP10);
    end
    decel10 = (cur10 > STEP10) ? (cur10 - STEP10) : 10'd0;
  end

  always_comb begin
    state_n          = state_q;
    dwell_cnt_n      = dwell_cnt_q;
    tgt_dir_n        = tgt_dir_q;
    tgt_speed_n      = tgt_speed_q;
    out_dir_n        = out_dir;
    out_speed_n      = out_speed;
    out_mode_n       = out_mode;
    reversal_count_n = reversal_count;

    if (estop) begin
      // out_dir is deliberately left alone: after release the zero target
      // brings the direction back through the normal DWELL path.
      out_speed_n = '0;
      out_mode_n  = '0;
      tgt_dir_n   = 1'b0;
      tgt_speed_n = '0;
      state_n     = TRACK;
      dwell_cnt_n = '0;
    end else begin
      if (cmd_valid) begin
        tgt_dir_n   = cmd_dir;
        tgt_speed_n = cmd_speed;
        out_mode_n  = cmd_mode;
      end

      // Ramp decisions use the registered target, so a command landing on a
      // tick cycle takes effect from the following tick.
      unique case (state_q)
        TRACK: begin
          if (tick) begin
            if (out_dir == tgt_dir_q) begin
              out_speed_n = clamp9(toward10);
            end else if (out_speed != 9'd0) begin
              out_speed_n = clamp9(decel10);
            end else begin
              state_n     = DWELL;
              dwell_cnt_n = '0;
            end
          end
        end
        DWELL: begin
          out_speed_n = '0;
          if (tgt_dir_q == out_dir) begin
            // Command reverted during the dwell: abandon the flip.
            state_n     = TRACK;
            dwell_cnt_n = '0;
          end else if (tick) begin
            if (dwell_cnt_q == DWELL_LAST) begin
              out_dir_n        = tgt_dir_q;
              state_n          = TRACK;
              dwell_cnt_n      = '0;
              reversal_count_n = (reversal_count == 8'hFF) ? 8'hFF
                                                           : reversal_count + 8'd1;
            end else begin
              dwell_cnt_n = dwell_cnt_q + DWELL_ONE;
            end
          end
        end
        default: begin
          state_n     = TRACK;
          dwell_cnt_n = '0;
        end
      endcase
    end

    // Computed from next values so ramping is coherent with the outputs.
    ramping_n = (state_n == DWELL) ||
                (out_speed_n != tgt_speed_n) ||
                (out_dir_n != tgt_dir_n);
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q        <= TRACK;
      dwell_cnt_q    <= '0;
      tgt_dir_q      <= 1'b0;
      tgt_speed_q    <= '0;
      out_dir        <= 1'b0;
      out_speed      <= '0;
      out_mode       <= '0;
      ramping        <= 1'b0;
      reversal_count <= '0;
    end else begin
      state_q        <= state_n;
      dwell_cnt_q    <= dwell_cnt_n;
      tgt_dir_q      <= tgt_dir_n;
      tgt_speed_q    <= tgt_speed_n;
      out_dir        <= out_dir_n;
      out_speed      <= out_speed_n;
      out_mode       <= out_mode_n;
      ramping        <= ramping_n;
      reversal_count <= reversal_count_n;
    end
  end

endmodule

// File: tb/tb_motor_ramp.sv
// -----------------------------------------------------------------------------
// tb_motor_ramp
//
// Directed bench for motor_ramp with STEP=4, TICK_DIV=16, DWELL_TICKS=3.
// Every change of the output bundle {out_dir, out_speed, out_mode, ramping,
// reversal_count} is matched against a queue of hand-computed snapshots that
// the driver pushes before issuing each command. A few latency-sensitive
// points are also checked directly at fixed cycles.
// -----------------------------------------------------------------------------
module tb_motor_ramp;

  localparam int SW = 21;  // dir(1) + speed(9) + mode(2) + ramping(1) + rev(8)

  // ---------------- clock / reset ----------------
  logic       sysclk = 1'b0;
  logic       rst    = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_dir   = 1'b0;
  logic [8:0] cmd_speed = '0;
  logic [1:0] cmd_mode  = '0;
  logic       estop     = 1'b0;
  logic       out_dir;
  logic [8:0] out_speed;
  logic [1:0] out_mode;
  logic       ramping;
  logic [7:0] reversal_count;
  logic       dbg_state;

  always #5 sysclk = ~sysclk;

  motor_ramp #(
    .STEP        (4),
    .TICK_DIV    (16),
    .DWELL_TICKS (3)
  ) dut (
    .sysclk         (sysclk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_dir        (cmd_dir),
    .cmd_speed      (cmd_speed),
    .cmd_mode       (cmd_mode),
    .estop          (estop),
    .out_dir        (out_dir),
    .out_speed      (out_speed),
    .out_mode       (out_mode),
    .ramping        (ramping),
    .reversal_count (reversal_count),
    .dbg_state      (dbg_state)
  );

  // Bench-side tick phase: value the prescaler should hold in this cycle.
  int pm = 0;
  always @(posedge sysclk) begin
    if (rst) pm <= 0;
    else     pm <= (pm == 15) ? 0 : pm + 1;
  end

  // ---------------- scoreboard ----------------
  int               checks   = 0;
  int               failures = 0;
  logic [SW-1:0]    exp_q[$];
  string            name_q[$];
  logic             mon_en = 1'b0;
  logic [SW-1:0]    prev_snap = '0;

  function automatic logic [SW-1:0] pack(input logic d, input int s, input int m,
                                         input logic r, input int rv);
    logic [8:0] s9;
    logic [1:0] m2;
    logic [7:0] r8;
    s9 = s[8:0];
    m2 = m[1:0];
    r8 = rv[7:0];
    return {d, s9, m2, r, r8};
  endfunction

  task automatic expect_snap(input string nm, input logic d, input int s, input int m,
                             input logic r, input int rv);
    exp_q.push_back(pack(d, s, m, r, rv));
    name_q.push_back(nm);
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // Monitor: every change of the output bundle consumes one expected snapshot.
  always @(negedge sysclk) begin
    logic [SW-1:0] cur;
    logic [SW-1:0] e;
    string         nm;
    if (mon_en) begin
      cur = {out_dir, out_speed, out_mode, ramping, reversal_count};
      if (cur !== prev_snap) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change got dir=%0d spd=%0d mode=%0d ramp=%0d rev=%0d",
                   cur[20], cur[19:11], cur[10:9], cur[8], cur[7:0]);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if (cur !== e) begin
            failures++;
            $display("FAIL %s got dir=%0d spd=%0d mode=%0d ramp=%0d rev=%0d exp dir=%0d spd=%0d mode=%0d ramp=%0d rev=%0d",
                     nm, cur[20], cur[19:11], cur[10:9], cur[8], cur[7:0],
                     e[20], e[19:11], e[10:9], e[8], e[7:0]);
          end
        end
        prev_snap = cur;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_pm(input int v);
    do @(negedge sysclk); while (pm != v);
  endtask

  // Return at the negedge just after the n-th upcoming tick edge.
  task automatic wait_ticks(input int n);
    repeat (n) wait_pm(15);
    @(negedge sysclk);
  endtask

  // Issue a command on a non-tick cycle (phase 3); returns after the edge.
  task automatic send(input logic d, input int s, input int m);
    wait_pm(3);
    cmd_dir   = d;
    cmd_speed = s[8:0];
    cmd_mode  = m[1:0];
    cmd_valid = 1'b1;
    @(negedge sysclk);
    cmd_valid = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic d;
    logic nd;
    int   rv;

    repeat (3) @(negedge sysclk);
    rst = 1'b0;
    @(negedge sysclk);
    chk("reset_dir", out_dir, 0);
    chk("reset_speed", out_speed, 0);
    chk("reset_mode", out_mode, 0);
    chk("reset_ramping", ramping, 0);
    chk("reset_rev", reversal_count, 0);
    chk("reset_state", dbg_state, 0);
    prev_snap = '0;
    mon_en    = 1'b1;

    // 1. Ramp up 0 -> 10, mode 1 with one-cycle latency
    expect_snap("t1_cmd",  0, 0,  1, 1, 0);
    expect_snap("t1_tick1", 0, 4,  1, 1, 0);
    expect_snap("t1_tick2", 0, 8,  1, 1, 0);
    expect_snap("t1_tick3", 0, 10, 1, 0, 0);
    send(0, 10, 1);
    chk("t1_mode_latency", out_mode, 1);
    chk("t1_no_ramp_yet", out_speed, 0);
    wait_ticks(4);
    chk("t1_hold10", out_speed, 10);

    // 2. Reversal 0/8 -> 1/8 via decel, dwell, flip, ramp
    expect_snap("t2_cmd8",  0, 10, 1, 1, 0);
    expect_snap("t2_to8",   0, 8,  1, 0, 0);
    send(0, 8, 1);
    wait_ticks(2);
    expect_snap("t2_cmdrev", 0, 8, 1, 1, 0);
    expect_snap("t2_dec4",   0, 4, 1, 1, 0);
    expect_snap("t2_dec0",   0, 0, 1, 1, 0);
    expect_snap("t2_flip",   1, 0, 1, 1, 1);
    expect_snap("t2_up4",    1, 4, 1, 1, 1);
    expect_snap("t2_up8",    1, 8, 1, 0, 1);
    send(1, 8, 1);
    wait_ticks(9);
    chk("t2_rev", reversal_count, 1);

    // 3. Dwell abort: reverse toward 0, revert during DWELL
    expect_snap("t3_cmdrev", 1, 8, 1, 1, 1);
    expect_snap("t3_dec4",   1, 4, 1, 1, 1);
    expect_snap("t3_dec0",   1, 0, 1, 1, 1);
    send(0, 8, 1);
    wait_ticks(3);
    chk("t3_in_dwell", dbg_state, 1);
    expect_snap("t3_up4", 1, 4, 1, 1, 1);
    expect_snap("t3_up8", 1, 8, 1, 0, 1);
    send(1, 8, 1);
    wait_ticks(3);
    chk("t3_rev_unchanged", reversal_count, 1);
    chk("t3_state_track", dbg_state, 0);

    // 4. Estop at dir1 speed200 mode2, with a competing command
    expect_snap("t4_cmd", 1, 8, 2, 1, 1);
    for (int s = 12; s < 200; s += 4) expect_snap("t4_ramp", 1, s, 2, 1, 1);
    expect_snap("t4_at200", 1, 200, 2, 0, 1);
    send(1, 200, 2);
    wait_ticks(49);
    expect_snap("t4_estop", 1, 0, 0, 1, 1);
    wait_pm(3);
    estop     = 1'b1;
    cmd_valid = 1'b1;
    cmd_dir   = 1'b1;
    cmd_speed = 9'd300;
    cmd_mode  = 2'd2;
    @(negedge sysclk);
    cmd_valid = 1'b0;
    chk("t4_estop_speed", out_speed, 0);
    chk("t4_estop_mode", out_mode, 0);
    chk("t4_estop_dir", out_dir, 1);
    wait_ticks(2);
    estop = 1'b0;
    expect_snap("t4_return_dir0", 0, 0, 0, 0, 2);
    wait_ticks(5);

    // 5. Boundaries
    expect_snap("t5_cmd509", 0, 0, 3, 1, 2);
    for (int s = 4; s <= 508; s += 4) expect_snap("t5_up", 0, s, 3, 1, 2);
    expect_snap("t5_at509", 0, 509, 3, 0, 2);
    send(0, 509, 3);
    wait_ticks(129);
    expect_snap("t5_cmd511", 0, 509, 3, 1, 2);
    expect_snap("t5_at511",  0, 511, 3, 0, 2);
    send(0, 511, 3);
    wait_ticks(2);
    chk("t5_no_wrap", out_speed, 511);
    expect_snap("t5_cmdrev", 0, 511, 3, 1, 2);
    for (int s = 507; s >= 3; s -= 4) expect_snap("t5_down", 0, s, 3, 1, 2);
    expect_snap("t5_floor0", 0, 0, 3, 1, 2);
    expect_snap("t5_flip",   1, 0, 3, 0, 3);
    send(1, 0, 3);
    wait_ticks(133);
    expect_snap("t5_cmd3", 1, 0, 3, 1, 3);
    expect_snap("t5_at3",  1, 3, 3, 0, 3);
    send(1, 3, 3);
    wait_ticks(2);
    expect_snap("t5_cmd2", 1, 3, 3, 1, 3);
    expect_snap("t5_at2",  1, 2, 3, 0, 3);
    send(1, 2, 3);
    wait_ticks(2);
    chk("t5_exact2", out_speed, 2);
    // command on the tick cycle: the tick uses target 2, not 20
    expect_snap("t5_tickcmd", 1, 2, 3, 1, 3);
    for (int s = 6; s <= 18; s += 4) expect_snap("t5_up20", 1, s, 3, 1, 3);
    expect_snap("t5_at20", 1, 20, 3, 0, 3);
    wait_pm(15);
    cmd_dir   = 1'b1;
    cmd_speed = 9'd20;
    cmd_mode  = 2'd3;
    cmd_valid = 1'b1;
    @(negedge sysclk);
    cmd_valid = 1'b0;
    chk("t5_tick_old_target", out_speed, 2);
    wait_ticks(6);

    // 6. Saturation of reversal_count, then reset mid-DWELL
    expect_snap("t6_cmd0", 1, 20, 0, 1, 3);
    for (int s = 16; s >= 4; s -= 4) expect_snap("t6_down", 1, s, 0, 1, 3);
    expect_snap("t6_at0", 1, 0, 0, 0, 3);
    send(1, 0, 0);
    wait_ticks(6);
    d  = 1'b1;
    rv = 3;
    for (int i = 0; i < 256; i++) begin
      nd = ~d;
      expect_snap("t6_rev_cmd", d, 0, 0, 1, rv);
      rv = (rv < 255) ? rv + 1 : 255;
      expect_snap("t6_rev_flip", nd, 0, 0, 0, rv);
      send(nd, 0, 0);
      wait_ticks(4);
      d = nd;
    end
    chk("t6_saturated", reversal_count, 255);

    expect_snap("t6_dwell_cmd", 1, 0, 0, 1, 255);
    send(0, 0, 0);
    wait_ticks(2);
    chk("t6_mid_dwell", dbg_state, 1);
    expect_snap("t6_reset", 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge sysclk);
    chk("t6_rst_dir", out_dir, 0);
    chk("t6_rst_rev", reversal_count, 0);
    chk("t6_rst_ramping", ramping, 0);
    chk("t6_rst_state", dbg_state, 0);
    rst = 1'b0;
    wait_ticks(5);
    chk("t6_quiet_after_rst", out_dir, 0);

    // ---------------- final report ----------------
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
